// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared types for the in-order issue stage and its scoreboard
package issue_scoreboard_pkg;

  localparam int REG_ID_W_DEF = 5;

  typedef logic [REG_ID_W_DEF-1:0] reg_id_t;

  typedef enum logic [1:0] {
    MOP_ALU    = 2'b00,
    MOP_MEM    = 2'b01,
    MOP_BRANCH = 2'b10,
    MOP_RSVD   = 2'b11
  } mop_class_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } issue_state_t;

  typedef enum logic [1:0] {
    STALL_NONE,
    STALL_RAW,
    STALL_STRUCT,
    STALL_REDIRECT
  } stall_cause_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/issue_scoreboard_sb_regfile_bits.sv
// rtl/issue_scoreboard_sb_regfile_bits.sv - pending-register bits with set/clear masks and sticky error
module sb_regfile_bits #(
  parameter int NREGS    = 32,
  parameter int REG_ID_W = 5,
  parameter int WB_PORTS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREGS-1:0]             set_mask,
  input  logic [WB_PORTS-1:0]          wb_vld,
  input  logic [REG_ID_W*WB_PORTS-1:0] wb_id,
  output logic [NREGS-1:0]             sb_busy,
  output logic                         sb_err
);

  logic [NREGS-1:0] clear_mask;
  logic             err_now;

  // A writeback to an idle register or two ports hitting one id is flagged but still clears.
  always_comb begin
    clear_mask = '0;
    err_now    = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_vld[p]) begin
        clear_mask[wb_id[p*REG_ID_W +: REG_ID_W]] = 1'b1;
        if (!sb_busy[wb_id[p*REG_ID_W +: REG_ID_W]]) err_now = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (wb_vld[q] && (wb_id[q*REG_ID_W +: REG_ID_W] == wb_id[p*REG_ID_W +: REG_ID_W]))
            err_now = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_busy <= '0;
      sb_err  <= 1'b0;
    end else begin
      sb_busy <= (sb_busy & ~clear_mask) | set_mask;
      sb_err  <= sb_err | err_now;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order multi-issue dispatch with register scoreboard; optional ISSUE_STALL_STATS_EN stall counters
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int NUM_ALU  = 2,
  parameter int NREGS    = 32,
  parameter int REG_ID_W = 5,
  parameter int WB_PORTS = 3,
  localparam int CNT_W   = $clog2(ISSUE_W+1),
  localparam int SLOT_W  = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1,
  localparam int ALU_W   = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CNT_W-1:0]             avail_cnt,
  input  logic [2*ISSUE_W-1:0]         mop_class,
  input  logic [ISSUE_W-1:0]           mop_src0_vld,
  input  logic [ISSUE_W-1:0]           mop_src1_vld,
  input  logic [ISSUE_W-1:0]           mop_dst_vld,
  input  logic [REG_ID_W*ISSUE_W-1:0]  mop_src0_id,
  input  logic [REG_ID_W*ISSUE_W-1:0]  mop_src1_id,
  input  logic [REG_ID_W*ISSUE_W-1:0]  mop_dst_id,
  input  logic [ISSUE_W-1:0]           mop_br_taken,
  input  logic [NUM_ALU-1:0]           alu_busy,
  input  logic                         mem_busy,
  input  logic [WB_PORTS-1:0]          wb_vld,
  input  logic [REG_ID_W*WB_PORTS-1:0] wb_id,
  input  logic                         redirect_ack,
  output logic [NUM_ALU-1:0]           alu_issue_vld,
  output logic [SLOT_W*NUM_ALU-1:0]    alu_issue_slot,
  output logic                         mem_issue_vld,
  output logic [SLOT_W-1:0]            mem_issue_slot,
  output logic [CNT_W-1:0]             deq_cnt,
  output logic                         redirect_req,
  output logic [NREGS-1:0]             sb_busy,
  output logic                         sb_err
`ifdef ISSUE_STALL_STATS_EN
  ,
  output logic [31:0]                  stat_raw,
  output logic [31:0]                  stat_struct,
  output logic [31:0]                  stat_redirect
`endif
);

  issue_state_t          state, next_state;
  stall_cause_t          cause;
  mop_class_t            cls;
  logic [CNT_W-1:0]      avail_eff, deq_c;
  logic [NREGS-1:0]      eff, set_mask;
  logic [NUM_ALU-1:0]    alu_claim, alu_vld_c;
  logic [SLOT_W*NUM_ALU-1:0] alu_slot_c;
  logic [SLOT_W-1:0]     mem_slot_c;
  logic [ALU_W-1:0]      alu_idx;
  logic [REG_ID_W-1:0]   src0, src1, dst;
  logic                  mem_claim, mem_vld_c, open, br_take, hazard, alu_ok, pipe_ok;

  assign avail_eff = (avail_cnt > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : avail_cnt;

  // eff accumulates dsts of earlier slots so a group never issues a RAW/WAW pair together.
  always_comb begin
    eff        = sb_busy;
    set_mask   = '0;
    alu_claim  = '0;
    alu_vld_c  = '0;
    alu_slot_c = '0;
    mem_claim  = 1'b0;
    mem_vld_c  = 1'b0;
    mem_slot_c = '0;
    deq_c      = '0;
    br_take    = 1'b0;
    open       = (state == ST_RUN);
    cause      = (state == ST_REDIRECT) ? STALL_REDIRECT : STALL_NONE;
    cls        = MOP_ALU;
    src0       = '0;
    src1       = '0;
    dst        = '0;
    hazard     = 1'b0;
    alu_ok     = 1'b0;
    alu_idx    = '0;
    pipe_ok    = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      cls    = mop_class_t'(mop_class[2*i +: 2]);
      src0   = mop_src0_id[i*REG_ID_W +: REG_ID_W];
      src1   = mop_src1_id[i*REG_ID_W +: REG_ID_W];
      dst    = mop_dst_id[i*REG_ID_W +: REG_ID_W];
      hazard = (mop_src0_vld[i] && eff[src0]) || (mop_src1_vld[i] && eff[src1]) ||
               (mop_dst_vld[i] && eff[dst]);
      alu_ok  = 1'b0;
      alu_idx = '0;
      for (int k = NUM_ALU-1; k >= 0; k--) begin
        if (!alu_busy[k] && !alu_claim[k]) begin
          alu_ok  = 1'b1;
          alu_idx = ALU_W'(k);
        end
      end
      pipe_ok = (cls == MOP_BRANCH) ? 1'b1 :
                (cls == MOP_MEM)    ? (!mem_busy && !mem_claim) : alu_ok;
      if (open && (i < int'(avail_eff))) begin
        if (hazard) begin
          open  = 1'b0;
          cause = STALL_RAW;
        end else if (!pipe_ok) begin
          open  = 1'b0;
          cause = STALL_STRUCT;
        end else begin
          deq_c = deq_c + CNT_W'(1);
          case (cls)
            MOP_MEM: begin
              mem_claim  = 1'b1;
              mem_vld_c  = 1'b1;
              mem_slot_c = SLOT_W'(i);
            end
            MOP_BRANCH: begin
              if (mop_br_taken[i]) begin
                br_take = 1'b1;
                open    = 1'b0;
              end
            end
            default: begin
              alu_claim[alu_idx] = 1'b1;
              alu_vld_c[alu_idx] = 1'b1;
              alu_slot_c[alu_idx*SLOT_W +: SLOT_W] = SLOT_W'(i);
            end
          endcase
          if (mop_dst_vld[i] && (cls != MOP_BRANCH)) begin
            eff[dst]      = 1'b1;
            set_mask[dst] = 1'b1;
          end
        end
      end else begin
        open = 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:      if (br_take) next_state = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ack) next_state = ST_RUN;
      default:     next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      redirect_req <= 1'b0;
    end else begin
      state        <= next_state;
      redirect_req <= (next_state == ST_REDIRECT);
    end
  end

  assign alu_issue_vld  = reset ? alu_vld_c  : '0;
  assign alu_issue_slot = reset ? alu_slot_c : '0;
  assign mem_issue_vld  = reset ? mem_vld_c  : 1'b0;
  assign mem_issue_slot = reset ? mem_slot_c : '0;
  assign deq_cnt        = reset ? deq_c      : '0;

  sb_regfile_bits #(
    .NREGS    (NREGS),
    .REG_ID_W (REG_ID_W),
    .WB_PORTS (WB_PORTS)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_mask (set_mask),
    .wb_vld   (wb_vld),
    .wb_id    (wb_id),
    .sb_busy  (sb_busy),
    .sb_err   (sb_err)
  );

`ifdef ISSUE_STALL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_raw      <= '0;
      stat_struct   <= '0;
      stat_redirect <= '0;
    end else if ((avail_eff != '0) && (deq_c < avail_eff)) begin
      case (cause)
        STALL_RAW:      stat_raw      <= sat_inc(stat_raw);
        STALL_STRUCT:   stat_struct   <= sat_inc(stat_struct);
        STALL_REDIRECT: stat_redirect <= sat_inc(stat_redirect);
        default: ;
      endcase
    end
  end
`else
  logic unused_cause;
  assign unused_cause = ^cause;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  avail_cnt;
  logic [3:0]  mop_class;
  logic [1:0]  mop_src0_vld, mop_src1_vld, mop_dst_vld, mop_br_taken;
  logic [9:0]  mop_src0_id, mop_src1_id, mop_dst_id;
  logic [1:0]  alu_busy;
  logic        mem_busy;
  logic [2:0]  wb_vld;
  logic [14:0] wb_id;
  logic        redirect_ack;
  logic [1:0]  alu_issue_vld, alu_issue_slot;
  logic        mem_issue_vld;
  logic [0:0]  mem_issue_slot;
  logic [1:0]  deq_cnt;
  logic        redirect_req;
  logic [31:0] sb_busy;
  logic        sb_err;
`ifdef ISSUE_STALL_STATS_EN
  logic [31:0] stat_raw, stat_struct, stat_redirect;
`endif

  typedef struct packed {
    logic [1:0] alu_vld;
    logic [1:0] alu_slot;
    logic       mem_vld;
    logic       mem_slot;
    logic [1:0] deq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .avail_cnt      (avail_cnt),
    .mop_class      (mop_class),
    .mop_src0_vld   (mop_src0_vld),
    .mop_src1_vld   (mop_src1_vld),
    .mop_dst_vld    (mop_dst_vld),
    .mop_src0_id    (mop_src0_id),
    .mop_src1_id    (mop_src1_id),
    .mop_dst_id     (mop_dst_id),
    .mop_br_taken   (mop_br_taken),
    .alu_busy       (alu_busy),
    .mem_busy       (mem_busy),
    .wb_vld         (wb_vld),
    .wb_id          (wb_id),
    .redirect_ack   (redirect_ack),
    .alu_issue_vld  (alu_issue_vld),
    .alu_issue_slot (alu_issue_slot),
    .mem_issue_vld  (mem_issue_vld),
    .mem_issue_slot (mem_issue_slot),
    .deq_cnt        (deq_cnt),
    .redirect_req   (redirect_req),
    .sb_busy        (sb_busy),
    .sb_err         (sb_err)
`ifdef ISSUE_STALL_STATS_EN
    ,
    .stat_raw       (stat_raw),
    .stat_struct    (stat_struct),
    .stat_redirect  (stat_redirect)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    avail_cnt = '0; mop_class = '0; mop_br_taken = '0;
    mop_src0_vld = '0; mop_src1_vld = '0; mop_dst_vld = '0;
    mop_src0_id = '0; mop_src1_id = '0; mop_dst_id = '0;
    alu_busy = '0; mem_busy = 1'b0; wb_vld = '0; wb_id = '0; redirect_ack = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [1:0] cls,
                          input logic s0v, input logic [4:0] s0,
                          input logic s1v, input logic [4:0] s1,
                          input logic dv, input logic [4:0] d, input logic br);
    mop_class[2*i +: 2]   = cls;
    mop_src0_vld[i]       = s0v;
    mop_src0_id[5*i +: 5] = s0;
    mop_src1_vld[i]       = s1v;
    mop_src1_id[5*i +: 5] = s1;
    mop_dst_vld[i]        = dv;
    mop_dst_id[5*i +: 5]  = d;
    mop_br_taken[i]       = br;
  endtask

  // Push the expected issue result for the stimulus now on the inputs, then pop and compare it.
  task automatic run_cycle(input string tag, input logic [1:0] ev, input logic [1:0] es,
                           input logic mv, input logic ms, input logic [1:0] ed);
    exp_t e;
    e.alu_vld = ev; e.alu_slot = es; e.mem_vld = mv; e.mem_slot = ms; e.deq = ed;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, ".alu_vld"},  64'(alu_issue_vld),  64'(e.alu_vld));
    check_val({tag, ".alu_slot"}, 64'(alu_issue_slot), 64'(e.alu_slot));
    check_val({tag, ".mem_vld"},  64'(mem_issue_vld),  64'(e.mem_vld));
    check_val({tag, ".mem_slot"}, 64'(mem_issue_slot), 64'(e.mem_slot));
    check_val({tag, ".deq"},      64'(deq_cnt),        64'(e.deq));
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".alu_vld"}, 64'(alu_issue_vld), 64'd0);
    check_val({tag, ".alu_slot"}, 64'(alu_issue_slot), 64'd0);
    check_val({tag, ".mem_vld"}, 64'(mem_issue_vld), 64'd0);
    check_val({tag, ".deq"}, 64'(deq_cnt), 64'd0);
    check_val({tag, ".redir"}, 64'(redirect_req), 64'd0);
    check_val({tag, ".sb_busy"}, 64'(sb_busy), 64'd0);
    check_val({tag, ".sb_err"}, 64'(sb_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    avail_cnt = 2'd2;
    set_slot(0, MOP_ALU, 0, 0, 0, 0, 1, 5'd1, 0);
    set_slot(1, MOP_ALU, 0, 0, 0, 0, 1, 5'd2, 0);
    #2;
    check_all_zero("rst");
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    avail_cnt = 2'd2;
    set_slot(0, MOP_ALU, 0, 0, 0, 0, 1, 5'd1, 0);
    set_slot(1, MOP_ALU, 0, 0, 0, 0, 1, 5'd2, 0);
    run_cycle("dual_alu", 2'b11, 2'b10, 0, 0, 2'd2);
    clear_inputs();
    check_val("dual_alu.sb", 64'(sb_busy), 64'h6);

    avail_cnt = 2'd2;
    set_slot(0, MOP_ALU, 0, 0, 0, 0, 1, 5'd3, 0);
    set_slot(1, MOP_ALU, 1, 5'd3, 0, 0, 0, 0, 0);
    run_cycle("raw_grp", 2'b01, 2'b00, 0, 0, 2'd1);
    check_val("raw_grp.sb", 64'(sb_busy), 64'hE);
    clear_inputs();
    avail_cnt = 2'd1;
    set_slot(0, MOP_ALU, 1, 5'd3, 0, 0, 0, 0, 0);
    run_cycle("raw_stall0", 2'b00, 2'b00, 0, 0, 2'd0);
    run_cycle("raw_stall1", 2'b00, 2'b00, 0, 0, 2'd0);
    wb_vld = 3'b001; wb_id[4:0] = 5'd3;
    run_cycle("raw_wbcyc", 2'b00, 2'b00, 0, 0, 2'd0);
    wb_vld = '0;
    run_cycle("raw_issue", 2'b01, 2'b00, 0, 0, 2'd1);
    clear_inputs();
    check_val("raw.sb", 64'(sb_busy), 64'h6);
    check_val("raw.err", 64'(sb_err), 64'd0);

    avail_cnt = 2'd2;
    set_slot(0, MOP_MEM, 0, 0, 0, 0, 0, 0, 0);
    set_slot(1, MOP_MEM, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("mem_one", 2'b00, 2'b00, 1, 0, 2'd1);
    mem_busy = 1'b1;
    run_cycle("mem_busy", 2'b00, 2'b00, 0, 0, 2'd0);
    clear_inputs();

    avail_cnt = 2'd2;
    alu_busy = 2'b01;
    run_cycle("alu_busy0", 2'b10, 2'b00, 0, 0, 2'd1);
    alu_busy = 2'b00;
    avail_cnt = 2'd3;
    run_cycle("clamp", 2'b11, 2'b10, 0, 0, 2'd2);
    avail_cnt = 2'd2;
    set_slot(0, MOP_MEM, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("mem_alu", 2'b01, 2'b01, 1, 0, 2'd2);
    set_slot(0, MOP_BRANCH, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("br_nt", 2'b01, 2'b01, 0, 0, 2'd2);
    check_val("br_nt.redir", 64'(redirect_req), 64'd0);

    set_slot(0, MOP_BRANCH, 0, 0, 0, 0, 0, 0, 1);
    run_cycle("br_take", 2'b00, 2'b00, 0, 0, 2'd1);
    check_val("br_take.redir", 64'(redirect_req), 64'd1);
    set_slot(0, MOP_ALU, 0, 0, 0, 0, 0, 0, 0);
    wb_vld = 3'b010; wb_id[9:5] = 5'd1;
    for (int c = 0; c < 3; c++) begin
      run_cycle("redir", 2'b00, 2'b00, 0, 0, 2'd0);
      wb_vld = '0;
      check_val("redir.req", 64'(redirect_req), 64'd1);
    end
    redirect_ack = 1'b1;
    run_cycle("redir_ack", 2'b00, 2'b00, 0, 0, 2'd0);
    redirect_ack = 1'b0;
    check_val("ack.req", 64'(redirect_req), 64'd0);
    run_cycle("resume", 2'b11, 2'b10, 0, 0, 2'd2);
    clear_inputs();
    check_val("resume.sb", 64'(sb_busy), 64'h4);

    check_val("err.pre", 64'(sb_err), 64'd0);
    wb_vld = 3'b100; wb_id[14:10] = 5'd7;
    run_cycle("wb_err", 2'b00, 2'b00, 0, 0, 2'd0);
    wb_vld = '0;
    check_val("err.set", 64'(sb_err), 64'd1);
    run_cycle("idle", 2'b00, 2'b00, 0, 0, 2'd0);
    check_val("err.sticky", 64'(sb_err), 64'd1);
    check_val("err.sb", 64'(sb_busy), 64'h4);

    avail_cnt = 2'd2;
    set_slot(0, MOP_ALU, 0, 0, 0, 0, 1, 5'd9, 0);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("mid_rst");
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b1;

`ifdef ISSUE_STALL_STATS_EN
    avail_cnt = 2'd1;
    set_slot(0, MOP_ALU, 0, 0, 0, 0, 1, 5'd5, 0);
    run_cycle("st_set", 2'b01, 2'b00, 0, 0, 2'd1);
    set_slot(0, MOP_ALU, 1, 5'd5, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) run_cycle("st_raw", 2'b00, 2'b00, 0, 0, 2'd0);
    clear_inputs();
    check_val("stat_raw", 64'(stat_raw), 64'd4);
    check_val("stat_struct", 64'(stat_struct), 64'd0);
    check_val("stat_redirect", 64'(stat_redirect), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Parametrised in-order multi-issue dispatch stage with register scoreboard.
- Sits between the decode micro-op queue and the execution pipes (ALU pipes, memory pipe).
- Each cycle it issues up to ISSUE_W micro-ops from the queue head and reports the dequeue count.
- Improvements over fixed 2-wide dispatch:
  - any ALU op may use any free ALU pipe;
  - branch-redirect handshake FSM;
  - sticky scoreboard error detection.

Parameters:
- ISSUE_W, 2, max micro-ops examined/issued per cycle.
- NUM_ALU, 2, number of ALU pipes.
- NREGS, 32, scoreboard entries.
- REG_ID_W, 5, register id width (2**REG_ID_W >= NREGS).
- WB_PORTS, 3, writeback clear ports (NUM_ALU + 1 memory).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- avail_cnt  in  $clog2(ISSUE_W+1)  valid micro-ops at queue head
- mop_class  in  2*ISSUE_W  per slot: 00 ALU, 01 MEM, 10 BRANCH, 11 reserved (treated as ALU)
- mop_src0_vld, mop_src1_vld, mop_dst_vld  in  ISSUE_W each  operand valid flags
- mop_src0_id, mop_src1_id, mop_dst_id  in  REG_ID_W*ISSUE_W each  register ids
- mop_br_taken  in  ISSUE_W  branch resolved taken (only meaningful for class BRANCH)
- alu_busy  in  NUM_ALU  ALU pipe cannot accept
- mem_busy  in  1  memory pipe cannot accept
- wb_vld  in  WB_PORTS  writeback completes
- wb_id  in  REG_ID_W*WB_PORTS  completing destination
- redirect_ack  in  1  fetch has been redirected
- alu_issue_vld  out  NUM_ALU  ALU pipe k receives a micro-op
- alu_issue_slot  out  $clog2(ISSUE_W)*NUM_ALU  source slot for pipe k
- mem_issue_vld  out  1; mem_issue_slot  out  $clog2(ISSUE_W)
- deq_cnt  out  $clog2(ISSUE_W+1)  micro-ops consumed this cycle
- redirect_req  out  1  registered; request fetch resteer
- sb_busy  out  NREGS  registered scoreboard
- sb_err  out  1  sticky error

Behaviour:
- Reset (reset=0, async):
  - scoreboard = 0, state = RUN, redirect_req = 0, sb_err = 0.
  - All combinational issue outputs forced 0 while reset is low.
- State RUN: slots are evaluated in order 0..ISSUE_W-1. Slot i issues only if all of the following hold:
  - slots 0..i-1 issued;
  - i < avail_cnt;
  - no valid source and no valid destination is pending in the effective board;
  - a pipe is available.
- Effective board = registered sb_busy OR dsts issued by earlier slots this cycle (intra-group RAW/WAW stall).
- No writeback bypass: a wb this cycle does not unblock an issue until the next cycle.
- Pipe availability:
  - ALU: lowest-index pipe with alu_busy=0 that is not already claimed this cycle.
  - MEM: at most one per cycle, and only if mem_busy=0.
- BRANCH, not taken: consumed, no pipe used, no dst.
- BRANCH, taken: consumed and ends the group. Next cycle redirect_req=1 and state goes to REDIRECT.
- REDIRECT:
  - deq_cnt=0, no issue.
  - Stay until redirect_ack=1, then redirect_req=0 and return to RUN the following cycle.
  - redirect_ack while in RUN is ignored.
- deq_cnt = number of consecutive issued/consumed slots; the first stalled slot ends the group.
- Scoreboard update: next = (sb_busy & ~clear_mask) | set_mask.
  - set_mask = dsts issued this cycle.
  - clear_mask = ids on wb_vld ports.
- Error conditions: a wb to a non-pending id, or two wb ports with the same id in one cycle, sets sb_err (sticky until reset). The id is still cleared.
- Writebacks continue to clear the scoreboard during REDIRECT.
- avail_cnt > ISSUE_W is clamped to ISSUE_W.

Optional Feature:
- Macro: ISSUE_STALL_STATS_EN.
- Defined: adds outputs stat_raw, stat_struct, stat_redirect (32-bit each, reset 0, saturating). Each cycle with avail_cnt>0 and deq_cnt<avail_cnt increments the counter for the first-stalled slot's cause:
  - operand hazard → stat_raw;
  - pipe busy → stat_struct;
  - REDIRECT state → stat_redirect.
- Undefined: no counters, no ports, identical issue behaviour.

Decomposition:
- Shared package IssuePkg:
  - mop_class_t enum (ALU, MEM, BRANCH);
  - issue_state_t (RUN, REDIRECT);
  - typedef reg_id_t.
- One natural sub-module: sb_regfile_bits, the scoreboard register array with set/clear masks and error detection. The issue-selection logic stays in the top level.

Test Plan:
- 2 independent ALU ops (dst r1, r2), alu_busy=00 → both issue, alu_issue_slot={1,0}, deq_cnt=2, next cycle sb_busy bits 1,2 set.
- Slot0 ALU dst r3, slot1 ALU src0 r3 → only slot0 issues, deq_cnt=1. Slot1 stalls until the wb_id=r3 cycle, then issues the following cycle.
- Two MEM ops, mem_busy=0 → slot0 to mem pipe, slot1 stalls (deq_cnt=1). With mem_busy=1, neither issues (deq_cnt=0).
- Slot0 BRANCH taken, slot1 ALU → deq_cnt=1, then redirect_req=1 with deq_cnt=0 for 3 cycles. redirect_ack pulse → redirect_req=0, RUN resumes.
- wb_vld on r7 while sb_busy[7]=0 → sb_err=1 next cycle and stays 1. Asserting reset low mid-operation → all outputs 0 immediately.
- With ISSUE_STALL_STATS_EN defined, 4 cycles of RAW stall → stat_raw=4, other counters 0.
